hare_egress_buffer: RTL and testbench

Egress stage directly downstream of the hare compute stage. It captures the per-cycle result word and rebirth flag, queues them in a first-word-fall-through FIFO, and hands them to the consumer over a valid/ready handshake. The hare stage has no backpressure, so this block absorbs consumer stalls, drops and counts words on overflow, and tracks how many rebirth-tagged results are in flight.

---
 rtl/trinity_fpga_pkg.sv | 13 +
 rtl/hare_egress_ram.sv | 25 ++
 rtl/hare_egress_buffer.sv | 141 ++++++++++++++
 tb/tb_hare_egress_buffer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trinity_fpga_pkg.sv
// Shared definitions for the hare egress path: the flush FSM states and the
// saturating drop-counter width and ceiling.
package trinity_fpga_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } egress_state_e;

   localparam int                   DROP_CNT_W   = 16;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hare_egress_ram.sv
// Entry storage for the hare egress FIFO: synchronous write port and
// asynchronous read port so the head word falls through to the outputs.
module hare_egress_ram #(
   parameter int DEPTH = 8,
   parameter int DW    = 33
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   // NOTE: storage carries no reset; stale contents never escape because the
   // top masks every head output while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/hare_egress_buffer.sv
// Egress FWFT buffer behind the hare compute stage with drop counting and
// rebirth-tag tracking. Define HARE_EGRESS_PARITY_EN to store per-entry parity.
module hare_egress_buffer
   import trinity_fpga_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_rebirth,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_rebirth,
   output logic                       out_parity,
   output logic [$clog2(DEPTH):0]     level,
   output logic [$clog2(DEPTH):0]     rebirth_pending,
   output logic                       overflow,
   output logic [DROP_CNT_W-1:0]      drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
`ifdef HARE_EGRESS_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int EW = WIDTH + 1 + PAR_W;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   egress_state_e         state_q, state_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d, reb_q, reb_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_q, drop_d;

   logic          run, full, push, pop, drop, head_rebirth;
   logic [EW-1:0] wr_entry, rd_entry;

`ifdef HARE_EGRESS_PARITY_EN
   assign wr_entry   = {^in_data, in_rebirth, in_data};
   assign out_parity = out_valid & rd_entry[WIDTH+1];
`else
   assign wr_entry   = {in_rebirth, in_data};
   assign out_parity = 1'b0;
`endif

   hare_egress_ram #(
      .DEPTH (DEPTH),
      .DW    (EW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign run          = (state_q == RUN);
   assign full         = (level_q == DEPTH_L);
   assign head_rebirth = rd_entry[WIDTH];
   assign out_valid    = (level_q != '0) & run;
   assign pop          = out_valid & out_ready;
   assign push         = in_valid & run & (~full | pop);
   assign drop         = in_valid & run & full & ~pop;

   // NOTE: every _d gets its hold value first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d    = RUN;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      reb_d      = reb_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;
      if (!run || flush) begin
         // Flush wins over any same-edge push/pop; the FLUSH cycle clears again.
         state_d    = (run && flush) ? FLUSH : RUN;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         reb_d      = '0;
         overflow_d = 1'b0;
         drop_d     = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         case ({push & in_rebirth, pop & head_rebirth})
            2'b10:   reb_d = reb_q + 1'b1;
            2'b01:   reb_d = reb_q - 1'b1;
            default: reb_d = reb_q;
         endcase
         if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != DROP_CNT_MAX) drop_d = drop_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         reb_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         reb_q      <= reb_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign out_data        = out_valid ? rd_entry[WIDTH-1:0] : '0;
   assign out_rebirth     = out_valid & head_rebirth;
   assign level           = level_q;
   assign rebirth_pending = reb_q;
   assign overflow        = overflow_q;
   assign drop_count      = drop_q;

endmodule

// File: tb/tb_hare_egress_buffer.sv
// Directed self-checking bench for hare_egress_buffer (DEPTH=8, WIDTH=32).
module tb_hare_egress_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_rebirth, flush, out_ready;
   logic [31:0] in_data;
   logic        out_valid, out_rebirth, out_parity, overflow;
   logic [31:0] out_data;
   logic [3:0]  level, rebirth_pending;
   logic [15:0] drop_count;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef HARE_EGRESS_PARITY_EN
   localparam logic PAR_ON = 1'b1;
`else
   localparam logic PAR_ON = 1'b0;
`endif

   hare_egress_buffer #(.DEPTH(8), .WIDTH(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_data         (in_data),
      .in_rebirth      (in_rebirth),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_rebirth     (out_rebirth),
      .out_parity      (out_parity),
      .level           (level),
      .rebirth_pending (rebirth_pending),
      .overflow        (overflow),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_rebirth = 1'b0;
      flush = 1'b0; out_ready = 1'b0;
      #12;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL rst_level got %0d exp 0", level); end
      n_chk++; if (rebirth_pending !== 4'd0) begin n_fail++; $display("FAIL rst_rebirth_pending got %0d exp 0", rebirth_pending); end
      n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b exp 0", overflow); end
      n_chk++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rst_drop_count got %0d exp 0", drop_count); end
      n_chk++; if ({out_data, out_rebirth, out_parity} !== 34'd0) begin n_fail++; $display("FAIL rst_head got %h/%b/%b exp 0/0/0", out_data, out_rebirth, out_parity); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_flow();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'h12345678; in_rebirth = 1'b0;
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h12345678 || out_rebirth !== 1'b0) begin n_fail++; $display("FAIL basic_first got v=%b %h r=%b exp v=1 12345678 r=0", out_valid, out_data, out_rebirth); end
      n_chk++; if (rebirth_pending !== 4'd0 || level !== 4'd1) begin n_fail++; $display("FAIL basic_first_cnt got lvl=%0d rp=%0d exp 1/0", level, rebirth_pending); end
      in_data = 32'h61803398; in_rebirth = 1'b1;
      tick();
      n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h61803398 || out_rebirth !== 1'b1) begin n_fail++; $display("FAIL basic_second got v=%b %h r=%b exp v=1 61803398 r=1", out_valid, out_data, out_rebirth); end
      n_chk++; if (rebirth_pending !== 4'd1 || level !== 4'd1) begin n_fail++; $display("FAIL basic_second_cnt got lvl=%0d rp=%0d exp 1/1", level, rebirth_pending); end
      in_valid = 1'b0; in_rebirth = 1'b0;
      tick();
      n_chk++; if (rebirth_pending !== 4'd0 || level !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got lvl=%0d rp=%0d v=%b exp 0/0/0", level, rebirth_pending, out_valid); end
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'hA000_0000 + i; in_rebirth = (i % 2 == 0);
         tick();
      end
      n_chk++; if (level !== 4'd8 || rebirth_pending !== 4'd4) begin n_fail++; $display("FAIL fill_level got lvl=%0d rp=%0d exp 8/4", level, rebirth_pending); end
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hDEAD_0000 + i; in_rebirth = 1'b1;
         tick();
      end
      n_chk++; if (drop_count !== 16'd3 || overflow !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL fill_drop got dc=%0d ov=%b lvl=%0d exp 3/1/8", drop_count, overflow, level); end
      n_chk++; if (rebirth_pending !== 4'd4) begin n_fail++; $display("FAIL fill_drop_tag got %0d exp 4", rebirth_pending); end
      in_valid = 1'b0; in_rebirth = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (out_valid !== 1'b1 || out_data !== 32'hA000_0000 + i || out_rebirth !== (i % 2 == 0)) begin
            n_fail++; $display("FAIL drain_%0d got v=%b %h r=%b exp v=1 %h r=%b", i, out_valid, out_data, out_rebirth, 32'hA000_0000 + i, (i % 2 == 0));
         end
         tick();
      end
      n_chk++; if (level !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd3) begin n_fail++; $display("FAIL drain_end got lvl=%0d v=%b ov=%b dc=%0d exp 0/0/1/3", level, out_valid, overflow, drop_count); end
   endtask

   task automatic test_full_push_pop();
      out_ready = 1'b0; in_rebirth = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 32'hB000_0000 + i;
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 32'hB000_0008 + k;
         n_chk++; if (out_data !== 32'hB000_0000 + k) begin n_fail++; $display("FAIL fullpp_head_%0d got %h exp %h", k, out_data, 32'hB000_0000 + k); end
         tick();
      end
      n_chk++; if (level !== 4'd8 || drop_count !== 16'd3 || rebirth_pending !== 4'd0) begin n_fail++; $display("FAIL fullpp_cnt got lvl=%0d dc=%0d rp=%0d exp 8/3/0", level, drop_count, rebirth_pending); end
      in_valid = 1'b0;
      for (int k = 4; k < 12; k++) begin
         n_chk++; if (out_valid !== 1'b1 || out_data !== 32'hB000_0000 + k) begin n_fail++; $display("FAIL fullpp_drain_%0d got v=%b %h exp v=1 %h", k, out_valid, out_data, 32'hB000_0000 + k); end
         tick();
      end
      n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL fullpp_end got lvl=%0d exp 0", level); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = 32'hC000_0000 + i; in_rebirth = (i == 1 || i == 3);
         tick();
      end
      n_chk++; if (level !== 4'd5 || rebirth_pending !== 4'd2) begin n_fail++; $display("FAIL flush_pre got lvl=%0d rp=%0d exp 5/2", level, rebirth_pending); end
      flush = 1'b1; in_data = 32'hF000_0000; in_rebirth = 1'b1;
      tick();
      n_chk++; if (level !== 4'd0 || rebirth_pending !== 4'd0 || overflow !== 1'b0 || drop_count !== 16'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_clear got lvl=%0d rp=%0d ov=%b dc=%0d v=%b exp 0/0/0/0/0", level, rebirth_pending, overflow, drop_count, out_valid);
      end
      flush = 1'b0; in_data = 32'hF000_0001;
      tick();
      n_chk++; if (level !== 4'd0 || out_valid !== 1'b0 || drop_count !== 16'd0) begin n_fail++; $display("FAIL flush_ignored got lvl=%0d v=%b dc=%0d exp 0/0/0", level, out_valid, drop_count); end
      in_data = 32'hF000_0002; in_rebirth = 1'b0;
      tick();
      n_chk++; if (level !== 4'd1 || out_valid !== 1'b1 || out_data !== 32'hF000_0002) begin n_fail++; $display("FAIL flush_resume got lvl=%0d v=%b %h exp 1/1/f0000002", level, out_valid, out_data); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_rebirth = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = 32'hE000_0000 + i;
         tick();
      end
      in_valid = 1'b0; in_rebirth = 1'b0;
      n_chk++; if (level !== 4'd6) begin n_fail++; $display("FAIL rstmid_pre got lvl=%0d exp 6", level); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0 || level !== 4'd0 || rebirth_pending !== 4'd0 || out_data !== 32'd0 || out_rebirth !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async got v=%b lvl=%0d rp=%0d %h r=%b exp 0/0/0/0/0", out_valid, level, rebirth_pending, out_data, out_rebirth);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_data = 32'h0BAD_CAFE;
      tick();
      in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_CAFE || level !== 4'd1) begin n_fail++; $display("FAIL rstmid_push got v=%b %h lvl=%0d exp 1/0badcafe/1", out_valid, out_data, level); end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_parity();
      out_ready = 1'b0; in_rebirth = 1'b0;
      in_valid = 1'b1; in_data = 32'h0000_0007;
      tick();
      n_chk++; if (out_parity !== PAR_ON || out_data !== 32'h7) begin n_fail++; $display("FAIL parity_odd got p=%b %h exp p=%b 7", out_parity, out_data, PAR_ON); end
      out_ready = 1'b1; in_data = 32'h0000_0003;
      tick();
      n_chk++; if (out_parity !== 1'b0 || out_data !== 32'h3) begin n_fail++; $display("FAIL parity_even got p=%b %h exp p=0 3", out_parity, out_data); end
      in_valid = 1'b0;
      tick();
      n_chk++; if (out_valid !== 1'b0 || out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_empty got v=%b p=%b exp 0/0", out_valid, out_parity); end
   endtask

   initial begin
      test_reset();
      test_basic_flow();
      test_fill_drain();
      test_full_push_pop();
      test_flush();
      test_reset_mid();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
